// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I MEM stage: D-cache request, lane alignment, stall FSM, MEM/WB register
module mem_access #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 0,
  parameter int CTRL_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     pc_in,
  input  logic [WIDTH-1:0]     pc_plus4_in,
  input  logic [WIDTH-1:0]     instruction_in,
  input  logic [CTRL_W-1:0]    ctrl_word_in,
  input  logic [WIDTH-1:0]     alu_in,
  input  logic [WIDTH-1:0]     rs2_in,
  input  logic [WIDTH-1:0]     br_en_in,
  input  logic                 stall_in,
  output logic                 data_read,
  output logic                 data_write,
  output logic [WIDTH/8-1:0]   data_mbe,
  output logic [WIDTH-1:0]     data_addr,
  output logic [WIDTH-1:0]     data_wdata,
  input  logic                 data_resp,
  input  logic [WIDTH-1:0]     data_rdata,
  output logic                 mem_stall,
  output logic                 mem_timeout,
  output logic [WIDTH-1:0]     pc_out,
  output logic [WIDTH-1:0]     pc_plus4_out,
  output logic [WIDTH-1:0]     instruction_out,
  output logic [CTRL_W-1:0]    ctrl_word_out,
  output logic [WIDTH-1:0]     alu_out,
  output logic [WIDTH-1:0]     br_en_out,
  output logic [WIDTH-1:0]     r_data_out,
  output logic [WIDTH-1:0]     w_data_out,
  output logic [WIDTH/8-1:0]   mem_byte_enable_out,
  output logic [WIDTH-1:0]     data_addr_out,
  output logic                 valid_out,
  output logic                 leap
);

  // Control word layout: [6:0] opcode, [9:7] funct3, [10] mem_read, [11] mem_write
  localparam int MBE_W     = WIDTH / 8;
  localparam int OFF_W     = $clog2(MBE_W);
  localparam int F3_LO     = 7;
  localparam int MEM_RD_B  = 10;
  localparam int MEM_WR_B  = 11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_req_rd;
  logic               r_req_wr;
  logic [MBE_W-1:0]   r_req_mbe;
  logic [WIDTH-1:0]   r_req_addr;
  logic [WIDTH-1:0]   r_req_wdata;
  logic [WIDTH-1:0]   r_held_rdata;
  logic [31:0]        r_wd_cnt;

  logic               w_is_rd;
  logic               w_is_wr;
  logic               w_memop;
  logic [1:0]         w_size;
  logic [OFF_W-1:0]   w_off;
  logic [MBE_W-1:0]   w_mbe_calc;
  logic [WIDTH-1:0]   w_wdata_calc;
  logic [WIDTH-1:0]   w_addr_calc;
  logic               w_advance;
  logic [31:0]        w_cnt_next;

  // A load wins if both flags are set so read and write never assert together
  assign w_is_rd      = ctrl_word_in[MEM_RD_B];
  assign w_is_wr      = ctrl_word_in[MEM_WR_B] & ~w_is_rd;
  assign w_memop      = valid_in & (w_is_rd | w_is_wr);
  assign w_size       = ctrl_word_in[F3_LO +: 2];
  assign w_off        = alu_in[OFF_W-1:0];
  assign w_wdata_calc = rs2_in << {w_off, 3'b000};
  assign w_addr_calc  = {alu_in[WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign w_advance    = ~mem_stall & ~stall_in;
  assign w_cnt_next   = r_wd_cnt + 32'd1;

  // Byte-lane enables from access size and address offset; halves at off=3 truncate
  always_comb begin
    w_mbe_calc = '1;
    case (w_size)
      2'b00:   w_mbe_calc = MBE_W'(1) << w_off;
      2'b01:   w_mbe_calc = MBE_W'(3) << w_off;
      default: w_mbe_calc = '1;
    endcase
  end

  // Stall FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, D-cache request and stall; WAIT/DONE replay the latched request
  always_comb begin
    w_state_next = r_state;
    data_read    = 1'b0;
    data_write   = 1'b0;
    data_mbe     = w_mbe_calc;
    data_addr    = w_addr_calc;
    data_wdata   = w_wdata_calc;
    mem_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          data_read  = w_is_rd;
          data_write = w_is_wr;
          if (data_resp) begin
            if (stall_in) w_state_next = S_DONE;
          end else begin
            mem_stall    = 1'b1;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        data_read  = r_req_rd;
        data_write = r_req_wr;
        data_mbe   = r_req_mbe;
        data_addr  = r_req_addr;
        data_wdata = r_req_wdata;
        mem_stall  = w_memop & ~data_resp;
        if (data_resp) w_state_next = stall_in ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        data_mbe   = r_req_mbe;
        data_addr  = r_req_addr;
        data_wdata = r_req_wdata;
        if (!stall_in) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch the request when it is issued so WAIT/DONE keep it stable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_rd    <= 1'b0;
      r_req_wr    <= 1'b0;
      r_req_mbe   <= '0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else if (r_state == S_IDLE && w_memop) begin
      r_req_rd    <= w_is_rd;
      r_req_wr    <= w_is_wr;
      r_req_mbe   <= w_mbe_calc;
      r_req_addr  <= w_addr_calc;
      r_req_wdata <= w_wdata_calc;
    end
  end

  // Capture read data on the completion that parks the FSM in DONE
  always_ff @(posedge clk) begin
    if (rst)                                              r_held_rdata <= '0;
    else if (r_state != S_DONE && w_state_next == S_DONE) r_held_rdata <= data_rdata;
  end

  // Watchdog: count WAIT cycles per access and set a sticky flag at TIMEOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (r_wd_cnt != '1) r_wd_cnt <= w_cnt_next;
      if ((TIMEOUT != 0) && (w_cnt_next == 32'(TIMEOUT))) mem_timeout <= 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // MEM/WB register: load the whole bundle on advance, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out              <= '0;
      pc_plus4_out        <= '0;
      instruction_out     <= '0;
      ctrl_word_out       <= '0;
      alu_out             <= '0;
      br_en_out           <= '0;
      r_data_out          <= '0;
      w_data_out          <= '0;
      mem_byte_enable_out <= '0;
      data_addr_out       <= '0;
      valid_out           <= 1'b0;
      leap                <= 1'b0;
    end else begin
      leap <= w_advance;
      if (w_advance) begin
        pc_out              <= pc_in;
        pc_plus4_out        <= pc_plus4_in;
        instruction_out     <= instruction_in;
        ctrl_word_out       <= ctrl_word_in;
        alu_out             <= alu_in;
        br_en_out           <= br_en_in;
        valid_out           <= valid_in;
        r_data_out          <= (w_memop & w_is_rd) ?
                               ((r_state == S_DONE) ? r_held_rdata : data_rdata) : '0;
        w_data_out          <= (w_memop & w_is_wr) ? data_wdata : '0;
        mem_byte_enable_out <= w_memop ? data_mbe : '0;
        data_addr_out       <= w_memop ? data_addr : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] pc_in, pc_plus4_in, instruction_in, alu_in, rs2_in, br_en_in;
  logic [11:0] ctrl_word_in;
  logic        stall_in;
  logic        data_read, data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr, data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        mem_stall, mem_timeout;
  logic [31:0] pc_out, pc_plus4_out, instruction_out, alu_out, br_en_out;
  logic [11:0] ctrl_word_out;
  logic [31:0] r_data_out, w_data_out, data_addr_out;
  logic [3:0]  mem_byte_enable_out;
  logic        valid_out, leap;

  int n_tests = 0;
  int n_fail  = 0;
  int n_reads;

  mem_access #(.WIDTH(32), .TIMEOUT(8), .CTRL_W(12)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in),
    .instruction_in(instruction_in), .ctrl_word_in(ctrl_word_in), .alu_in(alu_in),
    .rs2_in(rs2_in), .br_en_in(br_en_in), .stall_in(stall_in),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_resp(data_resp),
    .data_rdata(data_rdata), .mem_stall(mem_stall), .mem_timeout(mem_timeout),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .instruction_out(instruction_out),
    .ctrl_word_out(ctrl_word_out), .alu_out(alu_out), .br_en_out(br_en_out),
    .r_data_out(r_data_out), .w_data_out(w_data_out),
    .mem_byte_enable_out(mem_byte_enable_out), .data_addr_out(data_addr_out),
    .valid_out(valid_out), .leap(leap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ctrl(input logic [6:0] op, input logic [2:0] f3,
                                       input logic rd, input logic wr);
    return {wr, rd, f3, op};
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; ctrl_word_in = '0; alu_in = '0; rs2_in = '0;
    data_resp = 1'b0; data_rdata = '0; stall_in = 1'b0;
  endtask

  task automatic issue(input logic [11:0] cw, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic resp, input logic [31:0] rdata);
    valid_in = 1'b1; ctrl_word_in = cw; pc_in = pc; pc_plus4_in = pc + 32'd4;
    instruction_in = 32'h0000_0013; alu_in = alu; rs2_in = rs2; br_en_in = '0;
    data_resp = resp; data_rdata = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; pc_in = '0; pc_plus4_in = '0; instruction_in = '0; br_en_in = '0;
    idle_inputs();
    tick(); tick();
    check("rst_valid_out", valid_out, 0);
    check("rst_leap", leap, 0);
    check("rst_rdata_out", r_data_out, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_timeout", mem_timeout, 0);
    check("rst_read", data_read, 0);
    rst = 1'b0;

    // 1: lw hit in the same cycle
    issue(ctrl(7'b0000011, 3'b010, 1, 0), 32'h100, 32'h1004, 0, 1, 32'hDEADBEEF);
    #1;
    check("t1_read", data_read, 1);
    check("t1_write", data_write, 0);
    check("t1_mbe", data_mbe, 4'b1111);
    check("t1_addr", data_addr, 32'h1004);
    check("t1_stall", mem_stall, 0);
    tick(); idle_inputs();
    check("t1_rdata_out", r_data_out, 32'hDEADBEEF);
    check("t1_leap", leap, 1);
    check("t1_valid_out", valid_out, 1);
    check("t1_pc_out", pc_out, 32'h100);
    check("t1_mbe_out", mem_byte_enable_out, 4'b1111);

    // 2: sb at off=3 with three wait cycles
    issue(ctrl(7'b0100011, 3'b000, 0, 1), 32'h200, 32'h2003, 32'h0000_00AB, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_stall", mem_stall, 1);
      check("t2_write", data_write, 1);
      check("t2_read", data_read, 0);
      check("t2_mbe", data_mbe, 4'b1000);
      check("t2_wdata", data_wdata, 32'hAB00_0000);
      check("t2_addr", data_addr, 32'h2000);
      tick();
      check("t2_leap_held", leap, 0);
    end
    data_resp = 1'b1;
    #1;
    check("t2_stall_resp", mem_stall, 0);
    tick(); idle_inputs();
    check("t2_wdata_out", w_data_out, 32'hAB00_0000);
    check("t2_mbe_out", mem_byte_enable_out, 4'b1000);
    check("t2_rdata_out", r_data_out, 0);
    check("t2_addr_out", data_addr_out, 32'h2000);
    check("t2_leap", leap, 1);

    // 3: byte enables for half/byte at various offsets
    issue(ctrl(7'b0000011, 3'b001, 1, 0), 32'h300, 32'h3003, 0, 1, 32'h1111_2222);
    #1; check("t3_lh_mbe", data_mbe, 4'b1000);
    tick();
    issue(ctrl(7'b0000011, 3'b101, 1, 0), 32'h304, 32'h3002, 0, 1, 32'h3333_4444);
    #1; check("t3_lhu_mbe", data_mbe, 4'b1100);
    tick();
    check("t3_lhu_rdata_out", r_data_out, 32'h3333_4444);
    issue(ctrl(7'b0000011, 3'b000, 1, 0), 32'h308, 32'h3002, 0, 1, 0);
    #1; check("t3_lb_mbe", data_mbe, 4'b0100);
    tick();
    issue(ctrl(7'b0100011, 3'b001, 0, 1), 32'h30C, 32'h3001, 32'h0000_1234, 1, 0);
    #1;
    check("t3_sh_mbe", data_mbe, 4'b0110);
    check("t3_sh_wdata", data_wdata, 32'h0012_3400);
    tick(); idle_inputs();
    check("t3_sh_wdata_out", w_data_out, 32'h0012_3400);

    // 4: lw hit under stall_in, held in DONE
    n_reads = 0;
    issue(ctrl(7'b0000011, 3'b010, 1, 0), 32'h400, 32'h4008, 0, 1, 32'hCAFE_F00D);
    stall_in = 1'b1;
    #1; n_reads += int'(data_read);
    check("t4_stall_hit", mem_stall, 0);
    tick();
    data_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      #1; n_reads += int'(data_read);
      check("t4_done_stall", mem_stall, 0);
      tick();
      check("t4_leap_held", leap, 0);
    end
    stall_in = 1'b0;
    #1; n_reads += int'(data_read);
    tick(); idle_inputs();
    check("t4_read_count", n_reads, 1);
    check("t4_rdata_out", r_data_out, 32'hCAFE_F00D);
    check("t4_leap", leap, 1);

    // 5: reset during WAIT, then an add passes through
    issue(ctrl(7'b0000011, 3'b010, 1, 0), 32'h500, 32'h5000, 0, 0, 0);
    tick();
    #1; check("t5_wait_read", data_read, 1);
    rst = 1'b1; idle_inputs();
    tick();
    check("t5_read", data_read, 0);
    check("t5_valid_out", valid_out, 0);
    check("t5_leap", leap, 0);
    check("t5_stall", mem_stall, 0);
    rst = 1'b0;
    issue(ctrl(7'b0110011, 3'b000, 0, 0), 32'h600, 32'h55, 32'h77, 0, 0);
    #1;
    check("t5_add_read", data_read, 0);
    check("t5_add_write", data_write, 0);
    check("t5_add_stall", mem_stall, 0);
    tick();
    check("t5_add_valid", valid_out, 1);
    check("t5_add_alu", alu_out, 32'h55);
    check("t5_add_pc", pc_out, 32'h600);
    check("t5_add_rdata", r_data_out, 0);
    check("t5_add_wdata", w_data_out, 0);
    check("t5_add_mbe", mem_byte_enable_out, 0);
    check("t5_add_leap", leap, 1);
    alu_in = 32'h66; stall_in = 1'b1;
    tick();
    check("t5_hold_alu", alu_out, 32'h55);
    check("t5_hold_leap", leap, 0);
    idle_inputs();

    // 6: watchdog fires after 8 WAIT cycles and stays set
    issue(ctrl(7'b0000011, 3'b010, 1, 0), 32'h700, 32'h6000, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("t6_timeout_7", mem_timeout, 0);
    tick();
    check("t6_timeout_8", mem_timeout, 1);
    tick(); tick();
    #1;
    check("t6_stall", mem_stall, 1);
    check("t6_timeout_hold", mem_timeout, 1);
    data_resp = 1'b1; data_rdata = 32'h600D_600D;
    #1; check("t6_stall_resp", mem_stall, 0);
    tick(); idle_inputs();
    check("t6_rdata_out", r_data_out, 32'h600D_600D);
    check("t6_leap", leap, 1);
    check("t6_timeout_sticky", mem_timeout, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
